// File: rtl/pipe_affine_pkg.sv
// Shared widths, W-bit signed limits and the sat/wrap narrowing used by pipe_affine.
// Narrowing works on a 128-bit signed container, so W may be at most 42.
package pipe_affine_pkg;

    localparam int MAX_IW = 128;

    typedef logic signed [MAX_IW-1:0] wide_t;

    // Full-precision internal width: X*CA is 2W, +CB is 2W+1, *CC is 3W+1, +CD is 3W+2.
    function automatic int iw_of(input int w);
        return 3 * w + 2;
    endfunction

    function automatic wide_t smax(input int w);
        return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t smin(input int w);
        return -(wide_t'(1) <<< (w - 1));
    endfunction

    function automatic logic is_ovf(input wide_t p, input int w);
        return (p > smax(w)) || (p < smin(w));
    endfunction

    // Caller keeps the low w bits; with sat clear that low-bit slice is the wrap result.
    function automatic wide_t narrow_y(input wide_t p, input int w, input logic sat);
        wide_t r;
        r = p;
        if (sat && is_ovf(p, w))
            r = (p < 0) ? smin(w) : smax(w);
        return r;
    endfunction

endpackage

// File: rtl/pipe_affine_stage.sv
// One elastic pipeline slot: valid bit plus data, loaded when en, async-cleared by rst.
module pipe_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          v_in,
    input  logic [DW-1:0] d_in,
    output logic          v_out,
    output logic [DW-1:0] d_out
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_out <= 1'b0;
            d_out <= '0;
        end else if (en) begin
            v_out <= v_in;
            d_out <= d_in;
        end
    end

endmodule

// File: rtl/pipe_affine.sv
// Three-stage elastic pipeline computing Y = (X*CA+CB)*CC+CD with overflow flag.
// Define PIPE_AFFINE_SAT_EN to clamp Y on overflow; otherwise Y wraps.
module pipe_affine
    import pipe_affine_pkg::*;
#(
    parameter int                  W  = 16,
    parameter logic signed [W-1:0] CA = W'(3),
    parameter logic signed [W-1:0] CB = W'(5),
    parameter logic signed [W-1:0] CC = W'(2),
    parameter logic signed [W-1:0] CD = W'(7)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] X,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] Y,
    output logic                ovf
);

    localparam int IW = iw_of(W);

`ifdef PIPE_AFFINE_SAT_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    logic                 en1, en2, en3;
    logic                 v1, v2, v3;
    logic signed [IW-1:0] p1_n, p2_n, p3_n;
    logic signed [IW-1:0] s1_q, s2_q;
    logic signed [W-1:0]  y_n;
    logic                 ovf_n;
    logic        [W:0]    s3_q;

    // A stage may advance when it is empty or its successor advances.
    assign en3      = !v3 || out_ready;
    assign en2      = !v2 || en3;
    assign en1      = !v1 || en2;
    assign in_ready = en1 && !rst;

    // Every operand is sign-extended to IW before use, so nothing truncates.
    assign p1_n = IW'(X) * IW'(CA);
    assign p2_n = (s1_q + IW'(CB)) * IW'(CC);
    assign p3_n = s2_q + IW'(CD);

    assign ovf_n = is_ovf(wide_t'(p3_n), W);
    assign y_n   = W'(narrow_y(wide_t'(p3_n), W, SAT));

    pipe_stage #(.DW(IW)) u_s1 (
        .clk(clk), .rst(rst), .en(en1),
        .v_in(in_valid), .d_in(p1_n),
        .v_out(v1), .d_out(s1_q)
    );

    pipe_stage #(.DW(IW)) u_s2 (
        .clk(clk), .rst(rst), .en(en2),
        .v_in(v1), .d_in(p2_n),
        .v_out(v2), .d_out(s2_q)
    );

    pipe_stage #(.DW(W + 1)) u_s3 (
        .clk(clk), .rst(rst), .en(en3),
        .v_in(v2), .d_in({ovf_n, y_n}),
        .v_out(v3), .d_out(s3_q)
    );

    // Stage 3 may hold a stale bubble payload; outputs read zero unless valid.
    assign out_valid = v3;
    assign Y         = v3 ? s3_q[W-1:0] : '0;
    assign ovf       = v3 && s3_q[W];

endmodule

// File: tb/tb_pipe_affine.sv
// Self-checking bench for pipe_affine: queue scoreboard plus directed literal vectors.
module tb_pipe_affine;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] X = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [15:0] Y;
    logic               ovf;

    int tests = 0;
    int fails = 0;
    int acc_cnt = 0;

    typedef struct {
        int y;
        bit o;
    } exp_t;

    exp_t q[$];
    exp_t e;
    exp_t h;

    pipe_affine dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .X(X),
        .out_valid(out_valid), .out_ready(out_ready), .Y(Y), .ovf(ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    // Reference: exact integer math, then range check and sat or wrap.
    function automatic exp_t model(input int x);
        exp_t   r;
        longint p;
        p   = (longint'(x) * 3 + 5) * 2 + 7;
        r.o = (p > 32767) || (p < -32768);
`ifdef PIPE_AFFINE_SAT_EN
        r.y = r.o ? ((p < 0) ? -32768 : 32767) : int'(p);
`else
        r.y = int'(shortint'(p));
`endif
        return r;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input int y, input int o);
        @(negedge clk);
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_y"}, int'(Y), y);
        chk({name, "_ovf"}, int'(ovf), o);
    endtask

    task automatic send1(input int x);
        in_valid = 1'b1;
        X = 16'(x);
        step();
        in_valid = 1'b0;
        step();
        step();
    endtask

    // Scoreboard: log accepted inputs, check every output transfer and idle zeros.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else begin
            if (in_valid && in_ready) begin
                q.push_back(model(int'(X)));
                acc_cnt++;
            end
            if (!out_valid) begin
                tests++;
                if (Y != 0 || ovf != 1'b0) begin
                    fails++;
                    $display("FAIL idle_zero: got Y=%0d ovf=%0d expected 0 0", Y, ovf);
                end
            end else if (out_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_out: got Y=%0d with no pending sample, expected none", Y);
                end else begin
                    e = q.pop_front();
                    if (int'(Y) != e.y || ovf != e.o) begin
                        fails++;
                        $display("FAIL sb_out: got Y=%0d ovf=%0d expected Y=%0d ovf=%0d",
                                 Y, ovf, e.y, e.o);
                    end
                end
            end
        end
    end

    initial begin
        int got[4];
        int n;
        int sent;
        int outs;
        bit acc;
        bit ia;

        // Reset state
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_y", int'(Y), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);

        // Model pinned by hand-computed values
        h = model(1);
        chk("model_1", h.y, 23);
        h = model(10000);
        chk("model_ovf", int'(h.o), 1);

        // Single sample latency and values
        send1(1);
        expect_out("x1", 23, 0);
        step();
        send1(-3);
        expect_out("xm3", -1, 0);
        step();

        // Back-to-back throughput
        in_valid = 1'b1;
        X = 16'(0); step();
        X = 16'(1); step();
        X = 16'(2); step();
        in_valid = 1'b0;
        expect_out("b2b0", 17, 0); step();
        expect_out("b2b1", 23, 0); step();
        expect_out("b2b2", 29, 0); step();

        // Overflow boundaries
        send1(10000);
`ifdef PIPE_AFFINE_SAT_EN
        expect_out("ovf_pos", 32767, 1);
`else
        expect_out("ovf_pos", -5519, 1);
`endif
        step();
        send1(-10000);
`ifdef PIPE_AFFINE_SAT_EN
        expect_out("ovf_neg", -32768, 1);
`else
        expect_out("ovf_neg", 5553, 1);
`endif
        step();

        // Stall with full pipe, then drain in order
        out_ready = 1'b0;
        in_valid = 1'b1;
        sent = 0;
        X = 16'(1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            acc = in_ready;
            step();
            if (acc) begin
                sent++;
                X = 16'(sent + 1);
            end
        end
        chk("stall_accepts", sent, 3);
        @(negedge clk);
        chk("stall_in_ready", int'(in_ready), 0);
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_y_hold", int'(Y), 23);
        step();
        out_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            ia = in_valid && in_ready;
            if (out_valid) begin
                if (n < 4) got[n] = int'(Y);
                n++;
            end
            step();
            if (ia) in_valid = 1'b0;
        end
        chk("drain_count", n, 4);
        chk("drain_0", got[0], 23);
        chk("drain_1", got[1], 29);
        chk("drain_2", got[2], 35);
        chk("drain_3", got[3], 41);

        // Random handshakes against the scoreboard
        acc_cnt = 0;
        for (int c = 0; c < 20000 && acc_cnt < 1000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) X = 16'($urandom);
            else X = 16'($urandom_range(0, 4000) - 2000);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("rand_accepted", acc_cnt, 1000);
        for (int c = 0; c < 20 && q.size() != 0; c++) step();
        step();
        chk("rand_drained", q.size(), 0);

        // Async reset with three samples in flight
        out_ready = 1'b0;
        in_valid = 1'b1;
        X = 16'(5); step();
        X = 16'(6); step();
        X = 16'(7); step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", int'(out_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_y", int'(Y), 0);
        chk("arst_ovf", int'(ovf), 0);
        chk("arst_in_ready", int'(in_ready), 0);
        step();
        rst = 1'b0;
        #1;
        chk("arst_release_ready", int'(in_ready), 1);
        out_ready = 1'b1;
        outs = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) outs++;
            step();
        end
        chk("no_stale", outs, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
